// File: rtl/mul_arbiter.sv
// Shares one pipelined 33x33 signed multiplier between an integer and an FPU requester.
// Define MUL_ARB_RR_EN for round-robin contention; otherwise integer has fixed priority.
module mul_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        int_req,
  input  logic [32:0] int_a,
  input  logic [32:0] int_b,
  output logic        int_gnt,
  output logic        int_res_valid,
  output logic [63:0] int_res,
  input  logic        fpu_req,
  input  logic [23:0] fpu_a,
  input  logic [23:0] fpu_b,
  output logic        fpu_gnt,
  output logic        fpu_res_valid,
  output logic [47:0] fpu_res,
  input  logic        flush,
  output logic [32:0] mul_a,
  output logic [32:0] mul_b,
  input  logic [65:0] mul_p,
  output logic        busy
);

  logic [LATENCY-1:0] tag_v_q, tag_v_d;
  logic [LATENCY-1:0] tag_o_q, tag_o_d;
  logic               res_v;
  logic               unused_p;

`ifdef MUL_ARB_RR_EN
  // last_fpu_q=1 means the FPU was granted most recently; reset value lets int win first
  logic last_fpu_q, last_fpu_d;

  always_comb begin
    int_gnt = 1'b0;
    fpu_gnt = 1'b0;
    if (rst_n && !flush) begin
      if (int_req && fpu_req) begin
        int_gnt = last_fpu_q;
        fpu_gnt = !last_fpu_q;
      end else begin
        int_gnt = int_req;
        fpu_gnt = fpu_req;
      end
    end
  end

  always_comb begin
    last_fpu_d = last_fpu_q;
    if (int_gnt) begin
      last_fpu_d = 1'b0;
    end else if (fpu_gnt) begin
      last_fpu_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_fpu_q <= 1'b1;
    end else begin
      last_fpu_q <= last_fpu_d;
    end
  end
`else
  always_comb begin
    int_gnt = rst_n && !flush && int_req;
    fpu_gnt = rst_n && !flush && fpu_req && !int_req;
  end
`endif

  // Tag pipeline mirrors the multiplier stages: valid bit plus owner (1 = FPU).
  always_comb begin
    tag_v_d = '0;
    tag_o_d = '0;
    if (!flush) begin
      tag_v_d[0] = int_gnt || fpu_gnt;
      tag_o_d[0] = fpu_gnt;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v_d[i] = tag_v_q[i-1];
        tag_o_d[i] = tag_o_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v_q <= '0;
      tag_o_q <= '0;
    end else begin
      tag_v_q <= tag_v_d;
      tag_o_q <= tag_o_d;
    end
  end

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (int_gnt) begin
      mul_a = int_a;
      mul_b = int_b;
    end else if (fpu_gnt) begin
      mul_a = {9'b0, fpu_a};
      mul_b = {9'b0, fpu_b};
    end
  end

  // A result landing in the flush cycle is dropped along with everything else.
  assign res_v         = tag_v_q[LATENCY-1] && !flush;
  assign int_res_valid = res_v && !tag_o_q[LATENCY-1];
  assign fpu_res_valid = res_v && tag_o_q[LATENCY-1];
  assign int_res       = int_res_valid ? mul_p[63:0] : 64'd0;
  assign fpu_res       = fpu_res_valid ? mul_p[47:0] : 48'd0;
  assign busy          = |tag_v_q;
  assign unused_p      = ^mul_p[65:64];

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter: LATENCY=2 and LATENCY=1 instances share stimulus,
// each with its own multiplier model and expected-result queue.
module tb_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        int_req, fpu_req, flush;
  logic [32:0] int_a, int_b;
  logic [23:0] fpu_a, fpu_b;

  logic        int_gnt, fpu_gnt, int_res_valid, fpu_res_valid, busy;
  logic [63:0] int_res;
  logic [47:0] fpu_res;
  logic [32:0] mul_a, mul_b;
  logic [65:0] mul_p;

  logic        int_gnt1, fpu_gnt1, int_res_valid1, fpu_res_valid1, busy1;
  logic [63:0] int_res1;
  logic [47:0] fpu_res1;
  logic [32:0] mul_a1, mul_b1;
  logic [65:0] mul_p1;

  logic [65:0] p2_s0, p2_s1, p1_s0;

  typedef struct {
    int          cyc;
    logic        own;
    logic [63:0] val;
  } exp_t;

  exp_t q2[$];
  exp_t q1[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

`ifdef MUL_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_arbiter #(.LATENCY(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .int_req(int_req), .int_a(int_a), .int_b(int_b), .int_gnt(int_gnt),
    .int_res_valid(int_res_valid), .int_res(int_res),
    .fpu_req(fpu_req), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_gnt(fpu_gnt),
    .fpu_res_valid(fpu_res_valid), .fpu_res(fpu_res),
    .flush(flush), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .busy(busy)
  );

  mul_arbiter #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .int_req(int_req), .int_a(int_a), .int_b(int_b), .int_gnt(int_gnt1),
    .int_res_valid(int_res_valid1), .int_res(int_res1),
    .fpu_req(fpu_req), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_gnt(fpu_gnt1),
    .fpu_res_valid(fpu_res_valid1), .fpu_res(fpu_res1),
    .flush(flush), .mul_a(mul_a1), .mul_b(mul_b1), .mul_p(mul_p1), .busy(busy1)
  );

  function automatic logic [65:0] prod(input logic [32:0] a, input logic [32:0] b);
    logic signed [65:0] sa, sb;
    sa = 66'($signed(a));
    sb = 66'($signed(b));
    return sa * sb;
  endfunction

  // External multiplier models
  always @(posedge clk) begin
    p2_s0 <= prod(mul_a, mul_b);
    p2_s1 <= p2_s0;
    p1_s0 <= prod(mul_a1, mul_b1);
  end
  assign mul_p  = p2_s1;
  assign mul_p1 = p1_s0;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int idx, input string tag, input logic iv, input logic fv,
                     input logic [63:0] ir, input logic [47:0] fr);
    exp_t e;
    bit   have;
    chk({tag, "_onehot"}, 66'(iv & fv), 66'd0);
    if (!iv) chk({tag, "_int_res_zero"}, 66'(ir), 66'd0);
    if (!fv) chk({tag, "_fpu_res_zero"}, 66'(fr), 66'd0);
    have = 1'b1;
    while (have) begin
      have = 1'b0;
      if (idx == 0 && q2.size() > 0 && q2[0].cyc < cyc) begin
        e = q2.pop_front();
        have = 1'b1;
      end else if (idx == 1 && q1.size() > 0 && q1[0].cyc < cyc) begin
        e = q1.pop_front();
        have = 1'b1;
      end
      if (have) chk({tag, "_missing_res_cycle"}, 66'(cyc), 66'(e.cyc));
    end
    if (iv || fv) begin
      if (idx == 0 && q2.size() > 0) begin
        e = q2.pop_front();
        have = 1'b1;
      end else if (idx == 1 && q1.size() > 0) begin
        e = q1.pop_front();
        have = 1'b1;
      end
      if (!have) begin
        chk({tag, "_unexpected_res"}, 66'({iv, fv}), 66'd0);
      end else begin
        chk({tag, "_res_owner"}, 66'(fv), 66'(e.own));
        chk({tag, "_res_cycle"}, 66'(cyc), 66'(e.cyc));
        if (e.own) chk({tag, "_fpu_res"}, 66'(fr), 66'(e.val[47:0]));
        else       chk({tag, "_int_res"}, 66'(ir), 66'(e.val));
      end
    end
  endtask

  always @(negedge clk) if (rst_n) mon(0, "lat2", int_res_valid, fpu_res_valid, int_res, fpu_res);
  always @(negedge clk) if (rst_n) mon(1, "lat1", int_res_valid1, fpu_res_valid1, int_res1, fpu_res1);

  task automatic step(input logic ir, input logic [32:0] ia, input logic [32:0] ib,
                      input logic fr, input logic [23:0] fa, input logic [23:0] fb,
                      input logic fl, input logic eig, input logic efg,
                      input logic [63:0] er, input logic ev, input logic ebusy);
    logic [32:0] ea, eb;
    @(posedge clk);
    #1;
    int_req = ir; int_a = ia; int_b = ib;
    fpu_req = fr; fpu_a = fa; fpu_b = fb;
    flush   = fl;
    @(negedge clk);
    ea = eig ? ia : (efg ? {9'b0, fa} : 33'd0);
    eb = eig ? ib : (efg ? {9'b0, fb} : 33'd0);
    chk("int_gnt", 66'({int_gnt1, int_gnt}), 66'({eig, eig}));
    chk("fpu_gnt", 66'({fpu_gnt1, fpu_gnt}), 66'({efg, efg}));
    chk("mul_a", {mul_a1, mul_a}, {ea, ea});
    chk("mul_b", {mul_b1, mul_b}, {eb, eb});
    chk("busy", 66'(busy), 66'(ebusy));
    if (ev && (eig || efg)) begin
      q2.push_back('{cyc + 2, efg, er});
      q1.push_back('{cyc + 1, efg, er});
    end
  endtask

  task automatic idle(input logic ebusy);
    step(1'b0, 33'd0, 33'd0, 1'b0, 24'd0, 24'd0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, ebusy);
  endtask

  task automatic ireq(input logic [32:0] a, input logic [32:0] b, input logic [63:0] er,
                      input logic ev, input logic ebusy);
    step(1'b1, a, b, 1'b0, 24'd0, 24'd0, 1'b0, 1'b1, 1'b0, er, ev, ebusy);
  endtask

  task automatic freq(input logic [23:0] a, input logic [23:0] b, input logic [63:0] er,
                      input logic ebusy);
    step(1'b0, 33'd0, 33'd0, 1'b1, a, b, 1'b0, 1'b0, 1'b1, er, 1'b1, ebusy);
  endtask

  // Both request with equal products (5*7) so only the owner differs
  task automatic both(input logic eig, input logic efg, input logic ebusy);
    step(1'b1, 33'd5, 33'd7, 1'b1, 24'd5, 24'd7, 1'b0, eig, efg, 64'd35, 1'b1, ebusy);
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_ctrl"}, 66'({int_gnt, fpu_gnt, int_res_valid, fpu_res_valid, busy,
                             int_gnt1, fpu_gnt1, int_res_valid1, fpu_res_valid1, busy1}), 66'd0);
    chk({tag, "_int_res"}, 66'(int_res | int_res1), 66'd0);
    chk({tag, "_fpu_res"}, 66'(fpu_res | fpu_res1), 66'd0);
    chk({tag, "_mul_ab"}, {mul_a | mul_a1, mul_b | mul_b1}, 66'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    int_req = 1'b1; int_a = 33'd9; int_b = 33'd9;
    fpu_req = 1'b1; fpu_a = 24'd3; fpu_b = 24'd3;
    flush = 1'b0;
    #3;
    rst_chk("reset");
    repeat (3) @(posedge clk);
    #1;
    int_req = 1'b0; fpu_req = 1'b0;
    rst_n = 1'b1;

    // single FPU op: 1.0 * 1.0 mantissas
    idle(1'b0);
    freq(24'h800000, 24'h800000, 64'h0000_4000_0000_0000, 1'b0);
    idle(1'b1); idle(1'b1); idle(1'b0);

    // contention, 4 cycles, then FPU alone
    both(1'b1, 1'b0, 1'b0);
    both(!RR, RR, 1'b1);
    both(1'b1, 1'b0, 1'b1);
    both(!RR, RR, 1'b1);
    freq(24'd5, 24'd7, 64'd35, 1'b1);
    idle(1'b1); idle(1'b1); idle(1'b0);

    // signed integer products
    ireq(33'h1FFFFFFFF, 33'd3, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b0);
    idle(1'b1); idle(1'b1); idle(1'b0);
    ireq(33'h100000000, 33'd2, 64'hFFFF_FFFE_0000_0000, 1'b1, 1'b0);
    ireq(33'h0FFFFFFFF, 33'h0FFFFFFFF, 64'hFFFF_FFFE_0000_0001, 1'b1, 1'b1);
    ireq(33'd100, 33'h1FFFFFFFE, 64'hFFFF_FFFF_FFFF_FF38, 1'b1, 1'b1);
    freq(24'hFFFFFF, 24'hFFFFFF, 64'h0000_FFFF_FE00_0001, 1'b1);
    freq(24'd1, 24'd2, 64'd2, 1'b1);
    idle(1'b1); idle(1'b1); idle(1'b0);

    // alternating owners back to back
    ireq(33'd2, 33'd3, 64'd6, 1'b1, 1'b0);
    freq(24'd4, 24'd5, 64'd20, 1'b1);
    ireq(33'd6, 33'd7, 64'd42, 1'b1, 1'b1);
    freq(24'd8, 24'd9, 64'd72, 1'b1);
    ireq(33'd10, 33'd11, 64'd110, 1'b1, 1'b1);
    freq(24'd12, 24'd13, 64'd156, 1'b1);
    idle(1'b1); idle(1'b1); idle(1'b0);

    // flush: previous grant discarded, grant right after flush survives
    ireq(33'd3, 33'd3, 64'd9, 1'b0, 1'b0);
    step(1'b1, 33'd3, 33'd3, 1'b0, 24'd0, 24'd0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
    ireq(33'd4, 33'd4, 64'd16, 1'b1, 1'b0);
    idle(1'b1); idle(1'b1); idle(1'b0);

    // last grant int; then async reset mid-cycle with ops in flight
    both(!RR, RR, 1'b0);
    ireq(33'd2, 33'd2, 64'd4, 1'b1, 1'b1);
    ireq(33'd3, 33'd3, 64'd9, 1'b1, 1'b1);
    fpu_req = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    rst_chk("midreset");
    while (q2.size() > 0 && q2[$].cyc > cyc) void'(q2.pop_back());
    while (q1.size() > 0 && q1[$].cyc > cyc) void'(q1.pop_back());
    repeat (2) @(posedge clk);
    #1;
    rst_chk("held_reset");
    int_req = 1'b0; fpu_req = 1'b0;
    rst_n = 1'b1;
    both(1'b1, 1'b0, 1'b0);
    idle(1'b1); idle(1'b1); idle(1'b0);

    repeat (4) @(negedge clk);
    chk("lat2_sb_empty", 66'(q2.size()), 66'd0);
    chk("lat1_sb_empty", 66'(q1.size()), 66'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter LATENCY, default 2, is the pipeline depth of the shared multiplier in cycles; legal range 1..4.
REQ-002 clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 int_req  input  1  integer multiply request; held until granted.
REQ-005 int_a, int_b  input  33 each  integer operands, already sign- or zero-extended by the requester.
REQ-006 int_gnt  output  1  integer request accepted this cycle.
REQ-007 int_res_valid  output  1  integer product valid this cycle.
REQ-008 int_res  output  64  integer product, mul_p[63:0].
REQ-009 fpu_req  input  1  FPU mantissa multiply request; held until granted.
REQ-010 fpu_a, fpu_b  input  24 each  mantissas including the hidden bit.
REQ-011 fpu_gnt  output  1  FPU request accepted this cycle.
REQ-012 fpu_res_valid  output  1  FPU product valid this cycle.
REQ-013 fpu_res  output  48  FPU product, mul_p[47:0].
REQ-014 flush  input  1  discard all in-flight operations.
REQ-015 mul_a, mul_b  output  33 each  operands driven to the shared multiplier.
REQ-016 mul_p  input  66  product, LATENCY cycles after its operands were presented.
REQ-017 busy  output  1  at least one operation is in flight.

Function
REQ-018 Grants are combinational from int_req, fpu_req, flush and the arbitration state; at most one grant is asserted per cycle.
REQ-019 The block accepts one new operation per cycle, with no stall.
REQ-020 In a cycle where flush=1, no grant is issued.
REQ-021 On int_gnt, mul_a=int_a and mul_b=int_b.
REQ-022 On fpu_gnt, mul_a and mul_b are {9'b0,fpu_a} and {9'b0,fpu_b}.
REQ-023 With no grant, mul_a and mul_b are 0.
REQ-024 A LATENCY-stage tag pipeline records {valid, owner} for each grant: owner 0 is the integer requester, owner 1 is the FPU.
REQ-025 A grant in cycle N produces the owner's res_valid=1 for exactly one cycle, in cycle N+LATENCY, with res taken from mul_p in that cycle.
REQ-026 At most one of int_res_valid and fpu_res_valid is asserted per cycle.
REQ-027 int_res and fpu_res are 0 when their valid is low.
REQ-028 flush=1 clears every tag-pipeline valid bit at the next edge.
REQ-029 Within the flush cycle itself, no res_valid is asserted.
REQ-030 A grant issued in the cycle immediately after flush is unaffected by the flush.
REQ-031 busy = OR of all tag-pipeline valid bits.
REQ-032 With only one requester active, that requester is granted every cycle it requests.
REQ-033 Back-to-back grants to alternating owners return results in grant order, each at exactly N+LATENCY.

Reset
REQ-034 While rst_n=0, all tag valid bits are 0.
REQ-035 While rst_n=0, every output is 0: grants, res_valid, res, mul_a/mul_b, busy.
REQ-036 While rst_n=0, the round-robin pointer is set so that the integer requester wins the first contention.
REQ-037 Reset asserted mid-operation discards all in-flight operations; no res_valid is produced for them after release.
REQ-038 The first grant is possible in the first cycle with rst_n=1.

Configuration
REQ-039 Macro MUL_ARB_RR_EN defined: on simultaneous int_req and fpu_req, the requester not granted most recently wins.
REQ-040 Macro MUL_ARB_RR_EN defined: the pointer updates on every grant, including uncontended grants.
REQ-041 Macro MUL_ARB_RR_EN not defined: fixed priority, integer always wins contention, and no pointer register exists.
REQ-042 Macro MUL_ARB_RR_EN not defined: FPU starvation under continuous int_req is accepted behaviour.

Verification
REQ-043 LATENCY=2, fpu_req with fpu_a=fpu_b=24'h800000 in cycle 5 -> fpu_gnt=1 in cycle 5; fpu_res_valid=1 in cycle 7 with fpu_res=48'h400000000000; busy high in cycles 6-7.
REQ-044 int_req and fpu_req held high for 4 cycles from cycle 0, with MUL_ARB_RR_EN -> grants int,fpu,int,fpu; without the macro -> int for all 4 cycles and fpu_gnt only in cycle 4.
REQ-045 int_a=33'h1FFFFFFFF (-1), int_b=33'd3 -> int_res=64'hFFFFFFFFFFFFFFFD at grant+LATENCY.
REQ-046 Grants in cycles 0 and 1, flush=1 in cycle 1 -> no int_gnt in cycle 1, no res_valid in cycles 2-3, busy=0 from cycle 2.
REQ-047 rst_n driven low asynchronously mid-cycle with 2 operations in flight -> all outputs 0 immediately; no res_valid after release; the first contention after release is won by int.
REQ-048 LATENCY=1, alternating int/fpu grants in cycles 0-5 -> res_valid alternates in cycles 1-6, never both high in the same cycle.
